// File: rtl/drive_assist_seq_pkg.sv
// Shared types and constants for the drive_assist_seq assist-current engine.
package drive_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL1,
      ST_MUL2,
      ST_MUL3,
      ST_SAT
   } drive_state_t;

   localparam logic [11:0] TORQUE_MIN_DEF  = 12'h380;
   localparam logic [11:0] SLEW_STEP_DEF   = 12'h040;

   localparam int INCLINE_SAT_MAX = 511;
   localparam int INCLINE_SAT_MIN = -512;
   localparam int CADENCE_OFFSET  = 32;

   localparam int ACC_W   = 30;
   localparam int CURR_W  = 12;
   localparam int MUL_A_W = 27;
   localparam int MUL_B_W = 9;

endpackage : drive_pkg

// File: rtl/drive_assist_seq_if.sv
// Handshake and operand bundle between sensor conditioning, the assist
// engine and the motor current loop.
interface drive_assist_seq_if;
   import drive_pkg::*;

   logic              start;
   logic [11:0]       avg_torque;
   logic [4:0]        cadence;
   logic              not_pedaling;
   logic [12:0]       incline;
   logic [2:0]        scale;
   logic              busy;
   logic              done;
   logic [CURR_W-1:0] target_curr;

   // Requester side: drives the operands and start, observes the result.
   modport master (
      output start, avg_torque, cadence, not_pedaling, incline, scale,
      input  busy, done, target_curr
   );

   // Engine side.
   modport slave (
      input  start, avg_torque, cadence, not_pedaling, incline, scale,
      output busy, done, target_curr
   );

endinterface : drive_assist_seq_if

// File: rtl/drive_mul_unit.sv
// Shared combinational 27x9 multiplier; the product is truncated to the
// 30-bit accumulator width.
module drive_mul_unit
   import drive_pkg::*;
(
   input  logic [MUL_A_W-1:0] a,
   input  logic [MUL_B_W-1:0] b,
   output logic [ACC_W-1:0]   p
);

   // Both operands widened to the accumulator width so the product is
   // evaluated at 30 bits and the upper bits simply fall away.
   assign p = {3'b000, a} * {21'd0, b};

endmodule : drive_mul_unit

// File: rtl/drive_assist_seq.sv
// Sequenced assist-current engine: captures operands on start, forms
// torque * incline * cadence * scale on one shared multiplier over three
// cycles, then saturates into a registered 12-bit target current.
// Optional feature: define DRIVE_SLEW_EN to rate-limit target_curr changes
// to SLEW_STEP per update.
module drive_assist_seq
   import drive_pkg::*;
#(
   parameter logic [11:0] TORQUE_MIN = TORQUE_MIN_DEF
`ifdef DRIVE_SLEW_EN
   ,
   parameter logic [11:0] SLEW_STEP  = SLEW_STEP_DEF
`endif
) (
   input  logic               clk,
   input  logic               rst,
   drive_assist_seq_if.slave  bus
);

   drive_state_t      state;
   logic [ACC_W-1:0]  acc;
   logic              busy;
   logic              done;
   logic [CURR_W-1:0] target_curr;

   // Latched operands for the computation in flight.
   logic [12:0]       torque_q;
   logic [8:0]        incline_q;
   logic [5:0]        cadence_q;
   logic [2:0]        scale_q;
   logic              not_pedaling_q;

   // Operand conditioning (evaluated from the live inputs, used on capture).
   logic [12:0]        torque_diff;
   logic [12:0]        torque_pos;
   logic signed [12:0] incline_s;
   logic signed [9:0]  incline_sat;
   logic signed [10:0] incline_factor;
   logic [8:0]         incline_lim;
   logic [5:0]         cadence_factor;

   logic               capture;

   assign capture = (state == ST_IDLE) && bus.start;

   // Condition the raw sensor operands into multiplier-ready magnitudes.
   always_comb begin
      torque_diff = {1'b0, bus.avg_torque} - {1'b0, TORQUE_MIN};
      torque_pos  = torque_diff[12] ? 13'd0 : torque_diff;

      incline_s = bus.incline;
      if (incline_s > INCLINE_SAT_MAX)
         incline_sat = 10'(INCLINE_SAT_MAX);
      else if (incline_s < INCLINE_SAT_MIN)
         incline_sat = 10'(INCLINE_SAT_MIN);
      else
         incline_sat = incline_s[9:0];

      incline_factor = {incline_sat[9], incline_sat} + 11'sd256;
      if (incline_factor < 11'sd0)
         incline_lim = 9'd0;
      else if (incline_factor > 11'sd511)
         incline_lim = 9'd511;
      else
         incline_lim = incline_factor[8:0];

      cadence_factor = (bus.cadence > 5'd1)
                     ? 6'(bus.cadence) + 6'(CADENCE_OFFSET) : 6'd0;
   end

   // Hold the conditioned operands so later input changes cannot disturb
   // the computation in flight.
   // NOTE: datapath holding registers carry no reset; they are always
   // loaded on capture before any state that reads them is entered.
   always_ff @(posedge clk) begin
      if (capture) begin
         torque_q       <= torque_pos;
         incline_q      <= incline_lim;
         cadence_q      <= cadence_factor;
         scale_q        <= bus.scale;
         not_pedaling_q <= bus.not_pedaling;
      end
   end

   // Route the appropriate operand pair to the shared multiplier per step.
   logic [MUL_A_W-1:0] mul_a;
   logic [MUL_B_W-1:0] mul_b;
   logic [ACC_W-1:0]   mul_p;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned and a latch is inferred.
      mul_a = '0;
      mul_b = '0;
      unique case (state)
         ST_MUL1: begin
            mul_a = {14'd0, torque_q};
            mul_b = incline_q;
         end
         ST_MUL2: begin
            mul_a = acc[MUL_A_W-1:0];
            mul_b = {3'b000, cadence_q};
         end
         ST_MUL3: begin
            mul_a = acc[MUL_A_W-1:0];
            mul_b = {6'd0, scale_q};
         end
         default: ;
      endcase
   end

   drive_mul_unit u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   // Saturate the accumulator and, when enabled, rate-limit the new target.
   logic [CURR_W-1:0] result;
   logic [CURR_W-1:0] target_next;

   always_comb begin
      result = (|acc[ACC_W-1:27]) ? 12'hFFF : acc[26:15];
      if (not_pedaling_q)
         result = '0;
`ifdef DRIVE_SLEW_EN
      begin
         logic [12:0] cur13;
         logic [12:0] res13;
         cur13 = {1'b0, target_curr};
         res13 = {1'b0, result};
         if (res13 > cur13)
            target_next = ((res13 - cur13) > {1'b0, SLEW_STEP})
                        ? 12'(cur13 + {1'b0, SLEW_STEP}) : result;
         else
            target_next = ((cur13 - res13) > {1'b0, SLEW_STEP})
                        ? 12'(cur13 - {1'b0, SLEW_STEP}) : result;
      end
`else
      target_next = result;
`endif
   end

   // Sequencer: IDLE -> MUL1 -> MUL2 -> MUL3 -> SAT -> IDLE, with
   // registered busy/done/target outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         acc         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         target_curr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of its neighbours.
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  busy  <= 1'b1;
                  state <= ST_MUL1;
               end
            end
            ST_MUL1: begin
               acc   <= mul_p;
               state <= ST_MUL2;
            end
            ST_MUL2: begin
               acc   <= mul_p;
               state <= ST_MUL3;
            end
            ST_MUL3: begin
               acc   <= mul_p;
               state <= ST_SAT;
            end
            ST_SAT: begin
               target_curr <= target_next;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.target_curr = target_curr;

endmodule : drive_assist_seq
